// File: rtl/tlul_demux_1n.sv
// TL-UL 1:N host-side demultiplexer with address decode and outstanding tracking.
// Optional error responder for unmapped addresses: define TLUL_DEMUX_ERR_RSP_EN.

package tlul_pkg;

    localparam logic [2:0] OpPutFull    = 3'h0;
    localparam logic [2:0] OpPutPartial = 3'h1;
    localparam logic [2:0] OpGet        = 3'h4;
    localparam logic [2:0] OpAck        = 3'h0;
    localparam logic [2:0] OpAckData    = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_demux_1n
    import tlul_pkg::*;
#(
    parameter int                  N              = 4,
    parameter int                  MaxOutstanding = 4,
    parameter logic [N-1:0][31:0]  AddrBase       = '0,
    parameter logic [N-1:0][31:0]  AddrMask       = '0
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o,
    output tl_h2d_t tl_d_o [N],
    input  tl_d2h_t tl_d_i [N],
    output logic    busy_o,
    output logic    unmapped_o
);

`ifdef TLUL_DEMUX_ERR_RSP_EN
    // Target N is the internal error responder.
    localparam int NT = N + 1;
`else
    // Unmapped requests fall through to the last device.
    localparam int NT = N;
`endif
    localparam int SW = $clog2(NT);
    localparam int CW = $clog2(MaxOutstanding + 1);

    logic [SW-1:0] tgt;
    logic          hit_any;
    logic          stall;
    logic          dev_ardy;
    logic          a_ready;
    logic          d_valid;
    logic          a_hs;
    logic          d_hs;
    tl_d2h_t       rsp;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sel_q, sel_d;

`ifdef TLUL_DEMUX_ERR_RSP_EN
    logic       err_vld_q, err_vld_d;
    logic [7:0] err_src_q, err_src_d;
    logic [1:0] err_size_q, err_size_d;
    logic       err_get_q, err_get_d;
`endif

    // Address decode: lowest matching index wins, misses go to the last target.
    always_comb begin
        hit_any = 1'b0;
        tgt     = SW'(NT - 1);
        for (int i = N - 1; i >= 0; i--) begin
            if ((tl_h_i.a_address & ~AddrMask[i]) == AddrBase[i]) begin
                hit_any = 1'b1;
                tgt     = SW'(i);
            end
        end
    end

    // Hold off a target switch while responses are owed, and cap the count.
    assign stall = ((cnt_q != '0) && (tgt != sel_q)) ||
                   (cnt_q == CW'(MaxOutstanding));

    // Readiness of the decoded target.
    always_comb begin
        dev_ardy = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (tgt == SW'(i)) dev_ardy = tl_d_i[i].a_ready;
        end
`ifdef TLUL_DEMUX_ERR_RSP_EN
        if (tgt == SW'(N)) dev_ardy = ~err_vld_q;
`endif
    end

    // Response source follows the last accepted target.
    always_comb begin
        rsp = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_q == SW'(i)) rsp = tl_d_i[i];
        end
`ifdef TLUL_DEMUX_ERR_RSP_EN
        if (sel_q == SW'(N)) begin
            rsp          = '0;
            rsp.d_valid  = err_vld_q;
            rsp.d_opcode = err_get_q ? OpAckData : OpAck;
            rsp.d_size   = err_size_q;
            rsp.d_source = err_src_q;
            rsp.d_data   = 32'hFFFF_FFFF;
            rsp.d_error  = 1'b1;
        end
`endif
    end

    assign a_ready = dev_ardy & ~stall & ~rst_i;
    assign d_valid = rsp.d_valid & ~rst_i;
    assign a_hs    = tl_h_i.a_valid & a_ready;
    assign d_hs    = d_valid & tl_h_i.d_ready;

    // Host-facing response channel.
    always_comb begin
        tl_h_o         = rsp;
        tl_h_o.a_ready = a_ready;
        tl_h_o.d_valid = d_valid;
    end

    // Device request fan-out; only the target sees a_valid, only sel sees d_ready.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid & ~stall & ~rst_i &
                                (tgt == SW'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready & (sel_q == SW'(i));
        end
    end

    // Outstanding count saturates at zero; sel tracks the accepted target.
    always_comb begin
        cnt_d = cnt_q;
        if (a_hs && !d_hs) begin
            cnt_d = cnt_q + CW'(1);
        end else if (d_hs && !a_hs && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
        sel_d = a_hs ? tgt : sel_q;
    end

    // Tracking state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

`ifdef TLUL_DEMUX_ERR_RSP_EN
    // Error responder: capture on accept, hold the reply until it is taken.
    always_comb begin
        err_vld_d  = err_vld_q;
        err_src_d  = err_src_q;
        err_size_d = err_size_q;
        err_get_d  = err_get_q;
        if (a_hs && (tgt == SW'(N))) begin
            err_vld_d  = 1'b1;
            err_src_d  = tl_h_i.a_source;
            err_size_d = tl_h_i.a_size;
            err_get_d  = (tl_h_i.a_opcode == OpGet);
        end else if (d_hs && (sel_q == SW'(N))) begin
            err_vld_d  = 1'b0;
        end
    end

    // Error responder registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_vld_q  <= 1'b0;
            err_src_q  <= '0;
            err_size_q <= '0;
            err_get_q  <= 1'b0;
        end else begin
            err_vld_q  <= err_vld_d;
            err_src_q  <= err_src_d;
            err_size_q <= err_size_d;
            err_get_q  <= err_get_d;
        end
    end
`endif

    assign busy_o     = (cnt_q != '0);
    assign unmapped_o = a_hs & ~hit_any;

endmodule

// File: tb/tb_tlul_demux_1n.sv
// Bench for tlul_demux_1n: directed scenarios followed by randomized traffic
// against a transaction-level model of routing, ordering and counting.

module tb_tlul_demux_1n;
    import tlul_pkg::*;

`ifdef TLUL_DEMUX_ERR_RSP_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam int MO  = 2;
    localparam int UNM = ERR ? 4 : 3;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t h_i;
    tl_d2h_t h_o;
    tl_h2d_t d_o [4];
    tl_d2h_t d_i [4];
    logic    busy;
    logic    unm;

    int total = 0;
    int bad   = 0;

    bit [31:0] base [4] = '{32'h0000_0000, 32'h1000_0000,
                            32'h2000_0000, 32'h4000_0000};
    bit [31:0] mask [4] = '{32'h0000_FFFF, 32'h0000_0FFF,
                            32'h0000_0FFF, 32'h0FFF_FFFF};

    tlul_demux_1n #(
        .N              (4),
        .MaxOutstanding (MO),
        .AddrBase       ({32'h4000_0000, 32'h2000_0000,
                          32'h1000_0000, 32'h0000_0000}),
        .AddrMask       ({32'h0FFF_FFFF, 32'h0000_0FFF,
                          32'h0000_0FFF, 32'h0000_FFFF})
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tl_h_i     (h_i),
        .tl_h_o     (h_o),
        .tl_d_o     (d_o),
        .tl_d_i     (d_i),
        .busy_o     (busy),
        .unmapped_o (unm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input bit v, input logic [2:0] op,
                            input logic [31:0] a, input logic [7:0] src,
                            input logic [1:0] sz);
        h_i.a_valid   = v;
        h_i.a_opcode  = op;
        h_i.a_address = a;
        h_i.a_source  = src;
        h_i.a_size    = sz;
        h_i.a_mask    = 4'hF;
        h_i.a_data    = 32'h1234_5678;
    endtask

    // First map entry whose non-masked bits equal its base.
    function automatic int ref_target(input bit [31:0] a, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((a & ~mask[i]) == base[i]) begin
                hit = 1'b1;
                return i;
            end
        end
        return UNM;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 6)
            0: return {16'h0000, r[15:0]};
            1: return 32'h1000_0000 | (r & 32'h0000_0FFF);
            2: return 32'h2000_0000 | (r & 32'h0000_0FFF);
            3: return 32'h4000_0000 | (r & 32'h0FFF_FFFF);
            4: return 32'h3000_0000;
            default: return r;
        endcase
    endfunction

    int        mcnt;
    int        msel;
    bit        merr;
    logic [7:0] merr_src;
    int        mpend [4];
    bit        dv [4];

    initial begin
        h_i = '0;
        for (int k = 0; k < 4; k++) begin
            d_i[k]          = '0;
            d_i[k].a_ready  = 1'b1;
            d_i[k].d_opcode = OpAckData;
            d_i[k].d_data   = 32'hA5A5_0000 + k;
            d_i[k].d_source = 8'(k);
        end

        // Reset forces the handshake outputs low.
        rst = 1'b1;
        host_req(1, OpGet, 32'h1000_0010, 8'd1, 2'd2);
        d_i[0].d_valid = 1'b1;
        h_i.d_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aready", h_o.a_ready, 0);
        chk("rst_dvalid", h_o.d_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_unmapped", unm, 0);
        chk("rst_dev1_avalid", d_o[1].a_valid, 0);
        d_i[0].d_valid = 1'b0;
        h_i.a_valid = 1'b0;
        rst = 1'b0;

        // Single Get with zero-latency request and response.
        tick();
        host_req(1, OpGet, 32'h1000_0010, 8'd1, 2'd2);
        #1;
        chk("t1_dev1_avalid", d_o[1].a_valid, 1);
        chk("t1_dev0_avalid", d_o[0].a_valid, 0);
        chk("t1_aready", h_o.a_ready, 1);
        chk("t1_busy0", busy, 0);
        tick();
        h_i.a_valid = 1'b0;
        d_i[1].d_valid = 1'b1;
        #1;
        chk("t1_busy1", busy, 1);
        chk("t1_dvalid", h_o.d_valid, 1);
        chk("t1_ddata", h_o.d_data, 32'hA5A5_0001);
        chk("t1_dready1", d_o[1].d_ready, 1);
        chk("t1_dready0", d_o[0].d_ready, 0);
        tick();
        d_i[1].d_valid = 1'b0;
        #1;
        chk("t1_busy_end", busy, 0);

        // Back-to-back Gets hit the outstanding cap.
        tick();
        host_req(1, OpGet, 32'h0000_0004, 8'd2, 2'd2);
        #1;
        chk("t2_acc1", h_o.a_ready, 1);
        tick();
        #1;
        chk("t2_acc2", h_o.a_ready, 1);
        chk("t2_busy", busy, 1);
        tick();
        #1;
        chk("t2_stall", h_o.a_ready, 0);
        chk("t2_stall_avalid", d_o[0].a_valid, 0);
        chk("t2_stall_busy", busy, 1);
        tick();
        d_i[0].d_valid = 1'b1;
        #1;
        chk("t2_stall_dhs", h_o.a_ready, 0);
        chk("t2_dvalid", h_o.d_valid, 1);
        tick();
        d_i[0].d_valid = 1'b0;
        #1;
        chk("t2_third", h_o.a_ready, 1);
        chk("t2_third_avalid", d_o[0].a_valid, 1);
        tick();
        h_i.a_valid = 1'b0;
        d_i[0].d_valid = 1'b1;
        #1;
        tick();
        #1;
        tick();
        d_i[0].d_valid = 1'b0;
        #1;
        chk("t2_drained", busy, 0);

        // Target switch waits for the previous target to drain.
        tick();
        host_req(1, OpGet, 32'h0000_0000, 8'd3, 2'd2);
        #1;
        chk("t3_get", h_o.a_ready, 1);
        tick();
        host_req(1, OpPutFull, 32'h2000_0000, 8'd4, 2'd2);
        #1;
        chk("t3_put_stall", h_o.a_ready, 0);
        chk("t3_dev2_low", d_o[2].a_valid, 0);
        tick();
        #1;
        chk("t3_dev2_low2", d_o[2].a_valid, 0);
        tick();
        d_i[0].d_valid = 1'b1;
        #1;
        chk("t3_final_d", h_o.a_ready, 0);
        chk("t3_final_d_dev2", d_o[2].a_valid, 0);
        tick();
        d_i[0].d_valid = 1'b0;
        #1;
        chk("t3_cnt0", busy, 0);
        chk("t3_dev2_high", d_o[2].a_valid, 1);
        chk("t3_put_acc", h_o.a_ready, 1);
        tick();
        h_i.a_valid = 1'b0;
        d_i[2].d_valid = 1'b1;
        d_i[2].d_opcode = OpAck;
        #1;
        chk("t3_ddata", h_o.d_data, 32'hA5A5_0002);
        chk("t3_dready2", d_o[2].d_ready, 1);
        tick();
        d_i[2].d_valid = 1'b0;
        d_i[2].d_opcode = OpAckData;
        #1;
        chk("t3_drained", busy, 0);

`ifdef TLUL_DEMUX_ERR_RSP_EN
        // Unmapped Get answered by the internal error responder.
        tick();
        host_req(1, OpGet, 32'h3000_0000, 8'd5, 2'd2);
        h_i.d_ready = 1'b0;
        #1;
        chk("t4_unmapped", unm, 1);
        chk("t4_aready", h_o.a_ready, 1);
        chk("t4_dev3_low", d_o[3].a_valid, 0);
        tick();
        h_i.a_valid = 1'b0;
        #1;
        chk("t4_unm_pulse", unm, 0);
        for (int k = 0; k < 4; k++) begin
            chk("t4_dvalid", h_o.d_valid, 1);
            chk("t4_derror", h_o.d_error, 1);
            chk("t4_dopcode", h_o.d_opcode, OpAckData);
            chk("t4_ddata", h_o.d_data, 32'hFFFF_FFFF);
            chk("t4_dsource", h_o.d_source, 5);
            chk("t4_dsize", h_o.d_size, 2);
            if (k == 3) h_i.d_ready = 1'b1;
            tick();
            #1;
        end
        chk("t4_done_dvalid", h_o.d_valid, 0);
        chk("t4_done_busy", busy, 0);
`else
        // Unmapped Put falls through to the last device.
        tick();
        host_req(1, OpPutFull, 32'h3000_0000, 8'd6, 2'd2);
        #1;
        chk("t5_dev3_avalid", d_o[3].a_valid, 1);
        chk("t5_unmapped", unm, 1);
        chk("t5_aready", h_o.a_ready, 1);
        tick();
        h_i.a_valid = 1'b0;
        d_i[3].d_valid = 1'b1;
        #1;
        chk("t5_unm_pulse", unm, 0);
        chk("t5_ddata", h_o.d_data, 32'hA5A5_0003);
        tick();
        d_i[3].d_valid = 1'b0;
        #1;
        chk("t5_drained", busy, 0);
`endif

        // A mapped hit on the last device is not flagged.
        tick();
        host_req(1, OpGet, 32'h4000_1234, 8'd8, 2'd2);
        h_i.d_ready = 1'b1;
        #1;
        chk("map3_unmapped", unm, 0);
        chk("map3_avalid", d_o[3].a_valid, 1);
        tick();
        h_i.a_valid = 1'b0;
        d_i[3].d_valid = 1'b1;
        #1;
        tick();
        d_i[3].d_valid = 1'b0;
        #1;
        chk("map3_drained", busy, 0);

        // Reset with two requests in flight.
        tick();
        host_req(1, OpGet, 32'h1000_0000, 8'd7, 2'd2);
        #1;
        tick();
        #1;
        tick();
        #1;
        chk("t6_busy", busy, 1);
        d_i[1].d_valid = 1'b1;
        #1;
        chk("t6_dvalid_pre", h_o.d_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_dvalid", h_o.d_valid, 0);
        chk("t6_rst_aready", h_o.a_ready, 0);
        h_i.a_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t6_late_dvalid", h_o.d_valid, 0);
        chk("t6_late_dready1", d_o[1].d_ready, 0);
        chk("t6_dready0", d_o[0].d_ready, 1);
        chk("t6_busy_after", busy, 0);
        d_i[1].d_valid = 1'b0;
        host_req(1, OpGet, 32'h1000_0000, 8'd9, 2'd2);
        #1;
        chk("t6_route", d_o[1].a_valid, 1);
        chk("t6_aready", h_o.a_ready, 1);
        tick();
        h_i.a_valid = 1'b0;
        d_i[1].d_valid = 1'b1;
        #1;
        chk("t6_rsp", h_o.d_valid, 1);
        tick();
        d_i[1].d_valid = 1'b0;
        #1;
        chk("t6_drained", busy, 0);

        // Randomized traffic against the transaction model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mcnt = 0;
        msel = 0;
        merr = 1'b0;
        merr_src = '0;
        for (int k = 0; k < 4; k++) begin
            mpend[k] = 0;
            dv[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int  t;
            bit  hit, stl, rdy, edv, ahs, dhs;
            logic [31:0] a;
            tick();
            a = rnd_addr();
            host_req(($urandom % 4) != 0,
                     ($urandom % 2) ? OpGet : OpPutFull,
                     a, 8'($urandom), 2'($urandom));
            h_i.d_ready = ($urandom % 3) != 0;
            for (int k = 0; k < 4; k++) begin
                d_i[k].a_ready = ($urandom % 4) != 0;
                d_i[k].d_valid = dv[k];
            end
            #1;
            t   = ref_target(a, hit);
            stl = ((mcnt != 0) && (t != msel)) || (mcnt == MO);
            rdy = ((t < 4) ? d_i[t].a_ready : !merr) && !stl;
            edv = (msel < 4) ? dv[msel] : merr;
            chk("rnd_aready", h_o.a_ready, rdy);
            chk("rnd_busy", busy, mcnt != 0);
            chk("rnd_dvalid", h_o.d_valid, edv);
            chk("rnd_unmapped", unm, h_i.a_valid && rdy && !hit);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rnd_avalid%0d", k), d_o[k].a_valid,
                    h_i.a_valid && !stl && (t == k));
            end
            if (edv && msel < 4) begin
                chk("rnd_ddata", h_o.d_data, 32'hA5A5_0000 + msel);
            end
            if (edv && msel == 4) begin
                chk("rnd_err_source", h_o.d_source, merr_src);
                chk("rnd_err_error", h_o.d_error, 1);
            end
            ahs = h_i.a_valid && rdy;
            dhs = edv && h_i.d_ready;
            if (ahs && !dhs) mcnt++;
            else if (dhs && !ahs && mcnt > 0) mcnt--;
            if (dhs) begin
                if (msel < 4) begin
                    mpend[msel]--;
                    dv[msel] = 1'b0;
                end else begin
                    merr = 1'b0;
                end
            end
            if (ahs) begin
                if (t < 4) begin
                    mpend[t]++;
                end else begin
                    merr = 1'b1;
                    merr_src = h_i.a_source;
                end
                msel = t;
            end
            for (int k = 0; k < 4; k++) begin
                if (!dv[k] && mpend[k] > 0 && ($urandom % 2) != 0)
                    dv[k] = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
